// File: rtl/biker_pkg.sv
// rtl/biker_pkg.sv - shared constants, types and helpers for the biker position logic
package biker_pkg;

  // Position is held in fixed point: 6 fractional bits, speeds in 1/64 px per frame
  localparam int FIXED_POINT_MULT = 64;
  localparam int FRAC_BITS        = 6;

  // Play-field limits for the biker's top-left corner, in pixels
  localparam int LEFT_BORDER   = 32;
  localparam int RIGHT_BORDER  = 576;
  localparam int TOP_BORDER    = 48;
  localparam int BOTTOM_BORDER = 416;

  // Start position table: X depends on the instance number, Y is common
  localparam int X_START_BASE = 64;
  localparam int X_START_STEP = 32;
  localparam int Y_START      = 96;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    MOVING
  } biker_move_state_t;

  typedef logic signed [10:0] pixel_coord_t;
  typedef logic signed [31:0] fixed_pos_t;

  // Border limits converted to the fixed-point domain
  localparam fixed_pos_t MIN_X = fixed_pos_t'(LEFT_BORDER * FIXED_POINT_MULT);
  localparam fixed_pos_t MAX_X = fixed_pos_t'(RIGHT_BORDER * FIXED_POINT_MULT);
  localparam fixed_pos_t MIN_Y = fixed_pos_t'(TOP_BORDER * FIXED_POINT_MULT);
  localparam fixed_pos_t MAX_Y = fixed_pos_t'(BOTTOM_BORDER * FIXED_POINT_MULT);

  // Drop the fractional bits to get the on-screen pixel (floor toward -inf)
  function automatic pixel_coord_t toPixel(input fixed_pos_t pos);
    return pixel_coord_t'(pos >>> FRAC_BITS);
  endfunction

endpackage

// File: rtl/biker_axis_step.sv
// rtl/biker_axis_step.sv - one-axis position step with clamp and bounce at the borders
module biker_axis_step
  import biker_pkg::*;
(
  input  logic signed [31:0] pos,
  input  logic signed [31:0] speed,
  input  logic               dir,
  input  logic signed [31:0] minPos,
  input  logic signed [31:0] maxPos,
  output logic signed [31:0] nxtPos,
  output logic               nxtDir
);

  fixed_pos_t rawPos;

  // Advance by speed in the current direction, then clamp and bounce off either border;
  // landing exactly on a border keeps the direction unchanged
  always_comb begin
    rawPos = dir ? (pos + speed) : (pos - speed);
    nxtPos = rawPos;
    nxtDir = dir;
    if (rawPos < minPos) begin
      nxtPos = minPos;
      nxtDir = 1'b1;
    end else if (rawPos > maxPos) begin
      nxtPos = maxPos;
      nxtDir = 1'b0;
    end
  end

endmodule

// File: rtl/biker_move.sv
// rtl/biker_move.sv - per-frame biker position integrator with border and obstacle bounce
module biker_move
  import biker_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic [3:0]         index,
  input  logic               loadCoordinates,
  input  logic               enableMove,
  input  logic               startOfFrame,
  input  logic signed [31:0] speedX,
  input  logic signed [31:0] speedY,
  input  logic               obstacleHit,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               dirRight,
  output logic               dirDown
);

  biker_move_state_t state, nxtState;

  fixed_pos_t posX, posY;
  fixed_pos_t startX, startY;
  fixed_pos_t stepX, stepY;
  logic       stepDirRight, stepDirDown;
  logic       hitPending;
  logic       yDirIn;
  logic       doStep;

  // Start position depends only on the instance number
  assign startX = fixed_pos_t'((X_START_BASE + int'(index) * X_START_STEP) * FIXED_POINT_MULT);
  assign startY = fixed_pos_t'(Y_START * FIXED_POINT_MULT);

  // A pending obstacle hit flips the Y direction before this frame's step is taken
  assign yDirIn = dirDown ^ hitPending;

  // Integrate only while moving; a coincident load takes precedence over the frame
  assign doStep = (state == MOVING) && startOfFrame && !loadCoordinates;

  biker_axis_step xStep (
    .pos    (posX),
    .speed  (speedX),
    .dir    (dirRight),
    .minPos (MIN_X),
    .maxPos (MAX_X),
    .nxtPos (stepX),
    .nxtDir (stepDirRight)
  );

  biker_axis_step yStep (
    .pos    (posY),
    .speed  (speedY),
    .dir    (yDirIn),
    .minPos (MIN_Y),
    .maxPos (MAX_Y),
    .nxtPos (stepY),
    .nxtDir (stepDirDown)
  );

  // State register
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state <= IDLE;
    end else begin
      state <= nxtState;
    end
  end

  // Next-state logic: load from anywhere lands in LOADED, enableMove gates MOVING
  always_comb begin
    nxtState = state;
    if (loadCoordinates) begin
      nxtState = LOADED;
    end else begin
      case (state)
        LOADED:  if (enableMove)  nxtState = MOVING;
        MOVING:  if (!enableMove) nxtState = LOADED;
        default: nxtState = state;
      endcase
    end
  end

  // Position, direction and pixel output registers
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      posX     <= '0;
      posY     <= '0;
      dirRight <= 1'b1;
      dirDown  <= 1'b1;
      topLeftX <= '0;
      topLeftY <= '0;
    end else if (loadCoordinates) begin
      posX     <= startX;
      posY     <= startY;
      dirRight <= ~index[0];
      dirDown  <= 1'b1;
      topLeftX <= toPixel(startX);
      topLeftY <= toPixel(startY);
    end else if (doStep) begin
      posX     <= stepX;
      posY     <= stepY;
      dirRight <= stepDirRight;
      dirDown  <= stepDirDown;
      topLeftX <= toPixel(stepX);
      topLeftY <= toPixel(stepY);
    end
  end

  // Sticky obstacle flag: any number of hits within a frame gives one reversal;
  // a hit arriving on the stepping cycle itself belongs to the following frame
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      hitPending <= 1'b0;
    end else if (loadCoordinates) begin
      hitPending <= 1'b0;
    end else if (doStep) begin
      hitPending <= obstacleHit;
    end else if (obstacleHit) begin
      hitPending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_biker_move.sv
// tb/tb_biker_move.sv - self-checking bench for biker_move with a behavioural position model
module tb_biker_move;

  logic               clk = 1'b0;
  logic               resetN = 1'b1;
  logic [3:0]         index = '0;
  logic               loadCoordinates = 1'b0;
  logic               enableMove = 1'b0;
  logic               startOfFrame = 1'b0;
  logic signed [31:0] speedX = '0;
  logic signed [31:0] speedY = '0;
  logic               obstacleHit = 1'b0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               dirRight;
  logic               dirDown;

  int passCount = 0;
  int totalCount = 0;

  // Behavioural model state: fixed-point position as plain integers
  int mX, mY;
  bit mR, mD, mHit, mLoaded, mEn;

  biker_move dut (
    .clk             (clk),
    .resetN          (resetN),
    .index           (index),
    .loadCoordinates (loadCoordinates),
    .enableMove      (enableMove),
    .startOfFrame    (startOfFrame),
    .speedX          (speedX),
    .speedY          (speedY),
    .obstacleHit     (obstacleHit),
    .topLeftX        (topLeftX),
    .topLeftY        (topLeftY),
    .dirRight        (dirRight),
    .dirDown         (dirDown)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dutVec();
    return {topLeftX, topLeftY, dirRight, dirDown};
  endfunction

  function automatic logic [23:0] expVec();
    return {11'(mX / 64), 11'(mY / 64), mR, mD};
  endfunction

  function automatic logic [23:0] litVec(input int x, input int y, input bit r, input bit d);
    return {11'(x), 11'(y), r, d};
  endfunction

  task automatic modelReset();
    mX = 0; mY = 0; mR = 1'b1; mD = 1'b1; mHit = 1'b0; mLoaded = 1'b0;
  endtask

  // One axis of the frame rule: move, then clamp to [lo,hi] and point back inward
  task automatic modelAxis(inout int p, inout bit d, input int spd, input int lo, input int hi);
    p = d ? p + spd : p - spd;
    if (p < lo) begin p = lo; d = 1'b1; end
    else if (p > hi) begin p = hi; d = 1'b0; end
  endtask

  task automatic modelFrame(input int sx, input int sy);
    if (mLoaded && mEn) begin
      if (mHit) mD = !mD;
      mHit = 1'b0;
      modelAxis(mX, mR, sx, 32 * 64, 576 * 64);
      modelAxis(mY, mD, sy, 48 * 64, 416 * 64);
    end
  endtask

  task automatic modelLoad(input int idx);
    mX = (64 + idx * 32) * 64;
    mY = 96 * 64;
    mR = ((idx & 1) == 0);
    mD = 1'b1;
    mHit = 1'b0;
    mLoaded = 1'b1;
  endtask

  task automatic doLoad(input int idx);
    @(negedge clk);
    index = 4'(idx);
    loadCoordinates = 1'b1;
    @(negedge clk);
    loadCoordinates = 1'b0;
    modelLoad(idx);
  endtask

  task automatic setEnable(input bit e);
    @(negedge clk);
    enableMove = e;
    @(negedge clk);
    @(negedge clk);
    mEn = e;
  endtask

  task automatic doFrame(input int sx, input int sy);
    @(negedge clk);
    speedX = sx;
    speedY = sy;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    modelFrame(sx, sy);
  endtask

  task automatic doHit();
    @(negedge clk);
    obstacleHit = 1'b1;
    @(negedge clk);
    obstacleHit = 1'b0;
    mHit = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    repeat (3) @(negedge clk);
    resetN = 1'b0;
    modelReset();
    mEn = 1'b0;
    e = litVec(0, 0, 1'b1, 1'b1);
    totalCount++;
    if (dutVec() !== e) $display("FAIL reset_state: got %h want %h", dutVec(), e);
    else passCount++;
    // Frames in IDLE must not move anything even with enableMove high
    setEnable(1'b1);
    doFrame(300, 300);
    totalCount++;
    if (dutVec() !== e) $display("FAIL idle_frame: got %h want %h", dutVec(), e);
    else passCount++;
    setEnable(1'b0);
  endtask

  task automatic test_load();
    logic [23:0] e;
    doLoad(3);
    e = litVec(160, 96, 1'b0, 1'b1);
    totalCount++;
    if (dutVec() !== e) $display("FAIL load_idx3: got %h want %h", dutVec(), e);
    else passCount++;
  endtask

  task automatic test_move_x();
    logic [23:0] e;
    doLoad(2);
    setEnable(1'b1);
    for (int i = 1; i <= 5; i++) begin
      doFrame(128, 0);
      e = litVec(128 + 2 * i, 96, 1'b1, 1'b1);
      totalCount++;
      if (dutVec() !== e) $display("FAIL move_x frame %0d: got %h want %h", i, dutVec(), e);
      else passCount++;
    end
  endtask

  task automatic test_right_border();
    logic [23:0] e;
    doLoad(14);
    @(negedge clk);
    for (int i = 0; i < 63; i++) doFrame(64, 0);
    e = litVec(575, 96, 1'b1, 1'b1);
    totalCount++;
    if (dutVec() !== e) $display("FAIL approach_right: got %h want %h", dutVec(), e);
    else passCount++;
    doFrame(131, 0);
    e = litVec(576, 96, 1'b0, 1'b1);
    totalCount++;
    if (dutVec() !== e) $display("FAIL right_bounce: got %h want %h", dutVec(), e);
    else passCount++;
    doFrame(131, 0);
    e = litVec(573, 96, 1'b0, 1'b1);
    totalCount++;
    if (dutVec() !== e) $display("FAIL after_bounce: got %h want %h", dutVec(), e);
    else passCount++;
  endtask

  task automatic test_obstacle();
    logic [23:0] e;
    doLoad(0);
    @(negedge clk);
    repeat (3) doHit();
    doFrame(0, 90);
    e = litVec(64, 94, 1'b1, 1'b0);
    totalCount++;
    if (dutVec() !== e) $display("FAIL obstacle_reverse: got %h want %h", dutVec(), e);
    else passCount++;
    doFrame(0, 90);
    e = litVec(64, 93, 1'b1, 1'b0);
    totalCount++;
    if (dutVec() !== e) $display("FAIL obstacle_continue: got %h want %h", dutVec(), e);
    else passCount++;
  endtask

  task automatic test_load_vs_frame();
    logic [23:0] e;
    doFrame(100, 100);
    doFrame(100, 100);
    @(negedge clk);
    index = 4'd5;
    speedX = 200;
    speedY = 200;
    loadCoordinates = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    loadCoordinates = 1'b0;
    startOfFrame = 1'b0;
    modelLoad(5);
    e = litVec(224, 96, 1'b0, 1'b1);
    totalCount++;
    if (dutVec() !== e) $display("FAIL load_beats_frame: got %h want %h", dutVec(), e);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_freeze();
    logic [23:0] held;
    doFrame(250, 170);
    held = expVec();
    setEnable(1'b0);
    for (int i = 0; i < 10; i++) begin
      doFrame(500, 500);
      totalCount++;
      if (dutVec() !== held) $display("FAIL freeze frame %0d: got %h want %h", i, dutVec(), held);
      else passCount++;
    end
    // A hit while frozen stays pending until movement resumes
    doHit();
    setEnable(1'b1);
    doFrame(40, 70);
    totalCount++;
    if (dutVec() !== expVec()) $display("FAIL resume_after_hit: got %h want %h", dutVec(), expVec());
    else passCount++;
  endtask

  task automatic test_random();
    int act, sx, sy, nh;
    for (int i = 0; i < 120; i++) begin
      act = int'($urandom_range(0, 11));
      if (act == 0) begin
        doLoad(int'($urandom_range(0, 15)));
        @(negedge clk);
      end else if (act == 1) begin
        setEnable(!mEn);
      end else begin
        nh = (act > 8) ? int'($urandom_range(1, 3)) : 0;
        for (int h = 0; h < nh; h++) doHit();
        sx = int'($urandom_range(0, 3000));
        sy = int'($urandom_range(0, 3000));
        doFrame(sx, sy);
        totalCount++;
        if (dutVec() !== expVec())
          $display("FAIL random step %0d sx=%0d sy=%0d: got %h want %h", i, sx, sy, dutVec(), expVec());
        else passCount++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    if (!mEn) setEnable(1'b1);
    doLoad(7);
    @(negedge clk);
    doFrame(333, 222);
    @(negedge clk);
    #2 resetN = 1'b1;
    #1;
    modelReset();
    e = litVec(0, 0, 1'b1, 1'b1);
    totalCount++;
    if (dutVec() !== e) $display("FAIL async_reset: got %h want %h", dutVec(), e);
    else passCount++;
    @(negedge clk);
    resetN = 1'b0;
    doFrame(333, 222);
    totalCount++;
    if (dutVec() !== e) $display("FAIL post_reset_idle: got %h want %h", dutVec(), e);
    else passCount++;
  endtask

  initial begin
    modelReset();
    mEn = 1'b0;
    test_reset();
    test_load();
    test_move_x();
    test_right_border();
    test_obstacle();
    test_load_vs_frame();
    test_freeze();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
